// File: rtl/lut_array_cfg.sv
// Array of K-input LUT tiles loaded from a serial bitstream under valid/ready.
// Each tile is combinational or registered depending on its config mode bit.
module lut_array_cfg #(
  parameter int unsigned NUM_TILES  = 4,
  parameter int unsigned LUT_INPUTS = 5
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            cfg_start,
  input  logic                            cfg_valid,
  input  logic                            cfg_bit,
  output logic                            cfg_ready,
  output logic                            cfg_done,
  input  logic [NUM_TILES*LUT_INPUTS-1:0] tile_in,
  output logic [NUM_TILES-1:0]            tile_out
);

  localparam int unsigned TT_W       = 2 ** LUT_INPUTS;
  localparam int unsigned CFG_W      = TT_W + 1;
  localparam int unsigned TOTAL_BITS = NUM_TILES * CFG_W;
  localparam int unsigned CNT_W      = $clog2(TOTAL_BITS + 1);
  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(TOTAL_BITS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StActive
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [TOTAL_BITS-1:0] cfg_q, cfg_d;
  logic [NUM_TILES-1:0]  q_q, q_d;
  logic [NUM_TILES-1:0]  lut_d;
  logic [NUM_TILES-1:0]  mode;
  logic                  accept;

  // A start request in the same cycle wins over a valid bit, which is dropped.
  assign accept = (state_q == StLoad) && cfg_valid && !cfg_start;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cfg_d   = cfg_q;
    if (cfg_start) begin
      state_d = StLoad;
      cnt_d   = '0;
    end else if (accept) begin
      cfg_d[cnt_q] = cfg_bit;
      if (cnt_q == LastIdx) begin
        state_d = StActive;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  for (genvar t = 0; t < NUM_TILES; t++) begin : g_tile
    logic [CFG_W-1:0]      tile_cfg;
    logic [TT_W-1:0]       truth;
    logic [LUT_INPUTS-1:0] sel;

    assign tile_cfg = cfg_q[t*CFG_W +: CFG_W];
    assign truth    = tile_cfg[TT_W-1:0];
    assign sel      = tile_in[t*LUT_INPUTS +: LUT_INPUTS];
    assign lut_d[t] = truth[sel];
    assign mode[t]  = tile_cfg[TT_W];
  end

  // Tile flops only track the LUT while evaluating; leaving ACTIVE clears them.
  always_comb begin
    q_d      = '0;
    tile_out = '0;
    if (state_q == StActive) begin
      tile_out = (mode & q_q) | (~mode & lut_d);
      if (!cfg_start) begin
        q_d = lut_d;
      end
    end
  end

  assign cfg_ready = (state_q == StLoad);
  assign cfg_done  = (state_q == StActive);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      cfg_q   <= '0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cfg_q   <= cfg_d;
      q_q     <= q_d;
    end
  end

  cnt_in_range_a: assert property (@(posedge clock) disable iff (reset)
    (state_q == StLoad) |-> (cnt_q <= LastIdx));

endmodule
